// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: display modes and bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    localparam int MODE_COUNT = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_ROTL:   nxt = MODE_ROTR;
            MODE_ROTR:   nxt = MODE_BOUNCE;
            MODE_BOUNCE: nxt = MODE_OFF;
            MODE_OFF:    nxt = MODE_ROTL;
            default:     nxt = MODE_ROTL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low button.
// The debounced level follows the synchronised input only after CYC consecutive differing samples.
module btn_debounce #(
    parameter int CYC = 65536
) (
    input  logic clk0,
    input  logic reset,
    input  logic btn_raw,
    output logic level
);

    localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;

    // Synchronise the raw pin; idle (released) value is high.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            cnt_r   <= '0;
            level_r <= 1'b1;
        end else if (sync2_r != level_r) begin
            if (cnt_r == CW'(CYC - 1)) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                level_r <= level_r;
                cnt_r   <= cnt_r + CW'(1);
            end
        end else begin
            level_r <= level_r;
            cnt_r   <= '0;
        end
    end

    assign level = level_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Single-clock LED pattern generator: cascaded strobe prescaler, debounced buttons,
// speed ladder and four display modes driving a one-hot pattern.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 4,
    parameter int NUM_SPEEDS   = 6,
    parameter int BASE_DIV     = 500000,
    parameter int RATIO        = 10,
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic                                                     clk0,
    input  logic                                                     reset,
    input  logic [NUM_SPEEDS:0]                                      buttons,
    output logic [NUM_LEDS-1:0]                                      leds,
    output logic [1:0]                                               mode,
    output logic [((NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1)-1:0]   speed,
    output logic                                                     step
);

    localparam int SW = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int BW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int RW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int N  = NUM_LEDS;

    logic [NUM_SPEEDS:0]   btn_level_s;
    logic [NUM_SPEEDS:0]   pressed_s;
    logic [NUM_SPEEDS-1:0] tc_s;
    logic [NUM_SPEEDS-1:0] stb_s;
    logic [SW-1:0]         speed_sel_s;
    logic                  stb_sel_s;
    logic                  mode_adv_s;
    mode_e                 mode_nxt_s;
    logic [N-1:0]          pat_nxt_s;
    logic                  dir_nxt_s;
    logic [N-1:0]          leds_nxt_s;

    logic [N-1:0]          pattern_r;
    logic [N-1:0]          leds_r;
    logic                  dir_r;
    mode_e                 mode_r;
    logic [SW-1:0]         speed_r;
    logic                  step_r;
    logic                  adv_prev_r;

    for (genvar i = 0; i <= NUM_SPEEDS; i++) begin : g_btn
        btn_debounce #(.CYC(DEBOUNCE_CYC)) u_db (
            .clk0    (clk0),
            .reset   (reset),
            .btn_raw (buttons[i]),
            .level   (btn_level_s[i])
        );
    end

    assign pressed_s = ~btn_level_s;

    // Free-running prescaler stages; stage k advances only on stage k-1's strobe.
    for (genvar k = 0; k < NUM_SPEEDS; k++) begin : g_pre
        if (k == 0) begin : g_base
            logic [BW-1:0] cnt_r;
            // Stage 0 counts raw clk0 cycles.
            always_ff @(posedge clk0 or negedge reset) begin
                if (!reset) begin
                    cnt_r <= '0;
                end else if (cnt_r == BW'(BASE_DIV - 1)) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + BW'(1);
                end
            end
            assign tc_s[k] = (cnt_r == BW'(BASE_DIV - 1));
        end else begin : g_stage
            logic [RW-1:0] cnt_r;
            // Upper stages count strobes of the stage below.
            always_ff @(posedge clk0 or negedge reset) begin
                if (!reset) begin
                    cnt_r <= '0;
                end else if (stb_s[k-1]) begin
                    cnt_r <= (cnt_r == RW'(RATIO - 1)) ? '0 : cnt_r + RW'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end
            assign tc_s[k] = (cnt_r == RW'(RATIO - 1));
        end
    end

    // A stage strobes only when every stage below is also at terminal count.
    always_comb begin
        stb_s    = '0;
        stb_s[0] = tc_s[0];
        for (int k = 1; k < NUM_SPEEDS; k++) begin
            stb_s[k] = stb_s[k-1] & tc_s[k];
        end
    end

    // Highest pressed speed button wins; strobe of the currently selected stage.
    always_comb begin
        speed_sel_s = '0;
        stb_sel_s   = 1'b0;
        for (int i = 0; i < NUM_SPEEDS; i++) begin
            speed_sel_s = pressed_s[i] ? SW'(i) : speed_sel_s;
            stb_sel_s   = (speed_r == SW'(i)) ? stb_s[i] : stb_sel_s;
        end
    end

    // Next pattern, direction, mode and LED image.
    always_comb begin
        pat_nxt_s  = pattern_r;
        dir_nxt_s  = dir_r;
        mode_adv_s = pressed_s[NUM_SPEEDS] & ~adv_prev_r;
        mode_nxt_s = mode_adv_s ? next_mode(mode_r) : mode_r;
        if (step_r) begin
            case (mode_r)
                MODE_ROTL:   pat_nxt_s = {pattern_r[N-2:0], pattern_r[N-1]};
                MODE_ROTR:   pat_nxt_s = {pattern_r[0], pattern_r[N-1:1]};
                MODE_BOUNCE: begin
                    // An end-stop on the leading edge flips direction before moving.
                    if (dir_r == DIR_LEFT) begin
                        if (pattern_r[N-1]) begin
                            pat_nxt_s = {1'b0, pattern_r[N-1:1]};
                            dir_nxt_s = DIR_RIGHT;
                        end else begin
                            pat_nxt_s = {pattern_r[N-2:0], 1'b0};
                            dir_nxt_s = pat_nxt_s[N-1] ? DIR_RIGHT : DIR_LEFT;
                        end
                    end else begin
                        if (pattern_r[0]) begin
                            pat_nxt_s = {pattern_r[N-2:0], 1'b0};
                            dir_nxt_s = DIR_LEFT;
                        end else begin
                            pat_nxt_s = {1'b0, pattern_r[N-1:1]};
                            dir_nxt_s = pat_nxt_s[0] ? DIR_LEFT : DIR_RIGHT;
                        end
                    end
                end
                MODE_OFF:    pat_nxt_s = pattern_r;
                default:     pat_nxt_s = pattern_r;
            endcase
        end else begin
            pat_nxt_s = pattern_r;
        end
        if (mode_adv_s && (mode_nxt_s == MODE_BOUNCE)) begin
            dir_nxt_s = DIR_LEFT;
        end else begin
            dir_nxt_s = dir_nxt_s;
        end
        leds_nxt_s = (mode_nxt_s == MODE_OFF) ? '0 : pat_nxt_s;
    end

    // Control and output registers.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            pattern_r  <= N'(1);
            leds_r     <= N'(1);
            dir_r      <= DIR_LEFT;
            mode_r     <= MODE_ROTL;
            speed_r    <= '0;
            step_r     <= 1'b0;
            adv_prev_r <= 1'b0;
        end else begin
            pattern_r  <= pat_nxt_s;
            leds_r     <= leds_nxt_s;
            dir_r      <= dir_nxt_s;
            mode_r     <= mode_nxt_s;
            speed_r    <= speed_sel_s;
            step_r     <= stb_sel_s;
            adv_prev_r <= pressed_s[NUM_SPEEDS];
        end
    end

    assign leds  = leds_r;
    assign mode  = mode_r;
    assign speed = speed_r;
    assign step  = step_r;

endmodule
